// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop sync + per-channel counter debounce FSM, level and press/release pulses.
// Latency: btn_level/btn_press/btn_release change STABLE_CNT+2 cycles after a stable raw transition.
// Backpressure: none; free-running, outputs are registered every cycle. Optional macro: AUTO_REPEAT_EN.
module button_conditioner #(
    parameter int N_BTN         = 3,
    parameter int CNT_W         = 17,
    parameter int STABLE_CNT    = 100000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    // Commit happens when the counter reaches this value, so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    // Reject configurations the counter cannot represent.
    if (STABLE_CNT < 2 || STABLE_CNT > (2 ** CNT_W) - 1) begin : g_bad_stable_cnt
        $error("button_conditioner: STABLE_CNT out of range for CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [N_BTN-1:0] press_set;

    // Two-flop synchronizer; only s2 feeds the FSMs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // any_press is registered from the same next-cycle press bits so it lines up with btn_press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_set;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             commit_hi;
        logic             commit_lo;
        logic             rep_hit;

        // Commit conditions: input still at the new value on the last counted cycle.
        always_comb begin
            commit_hi = (state == S_WAIT_HI) && s2[i]  && (cnt == CNT_LAST);
            commit_lo = (state == S_WAIT_LO) && !s2[i] && (cnt == CNT_LAST);
        end

`ifdef AUTO_REPEAT_EN
        logic [REP_W-1:0] rep_cnt;
        logic             rep_armed;

        // First repeat uses the delay, later repeats the period; only while staying in S_HIGH.
        always_comb begin
            rep_hit = (state == S_HIGH) && s2[i] &&
                      (rep_cnt == (rep_armed ? REP_PERIOD_LAST : REP_DELAY_LAST));
        end

        // Repeat counter runs only while held in S_HIGH; any exit clears it.
        always_ff @(posedge clk) begin
            if (!rst_n || state != S_HIGH || !s2[i]) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (rep_hit) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt   <= rep_cnt + 1'b1;
            end
        end
`else
        assign rep_hit = 1'b0;
`endif

        assign press_set[i] = commit_hi | rep_hit;

        // Debounce FSM with registered level and single-cycle pulses.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state     <= S_LOW;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= press_set[i];
                release_q <= commit_lo;
                case (state)
                    S_LOW: begin
                        if (s2[i]) begin
                            state <= S_WAIT_HI;
                            cnt   <= '0;
                        end
                    end
                    S_WAIT_HI: begin
                        if (!s2[i]) begin
                            state <= S_LOW;
                            cnt   <= '0;
                        end else if (commit_hi) begin
                            state   <= S_HIGH;
                            cnt     <= '0;
                            level_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (!s2[i]) begin
                            state <= S_WAIT_LO;
                            cnt   <= '0;
                        end
                    end
                    S_WAIT_LO: begin
                        if (s2[i]) begin
                            state <= S_HIGH;
                            cnt   <= '0;
                        end else if (commit_lo) begin
                            state   <= S_LOW;
                            cnt     <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with N_BTN=2, STABLE_CNT=4.
// Vectors: inputs applied before a rising edge, outputs sampled on the following falling edge.
// Hand sequences cover channel independence, long hold (auto-repeat when enabled) and release.
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_press;

    button_conditioner #(
        .N_BTN(N), .CNT_W(4), .STABLE_CNT(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic         any;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input int cnt, input logic r, input logic [N-1:0] raw,
                       input logic [N-1:0] lvl, input logic [N-1:0] prs,
                       input logic [N-1:0] rel, input logic any);
        vec_t v;
        v.rst_n = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.any = any;
        for (int k = 0; k < cnt; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, want);
    endtask

    initial begin
        int  n;
        bit  found;
        int  bad;
        rst_n   = 1'b0;
        btn_raw = '0;

        // reset
        add(2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // single press on ch0: commit 6 edges after first high sample
        add(6, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(2, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        // release
        add(6, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // bounce: 3 high, 1 low, then steady high
        add(3, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        add(6, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        add(6, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // simultaneous press and release on both channels
        add(6, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 1);
        add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
        add(6, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b11, 0);
        add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        // reset at cnt==2, button held: fresh debounce after reset
        add(5, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(6, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        // one-cycle low glitch while high: no release
        add(1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        add(5, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        // reset while high clears the level
        add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n   = vecs[i].rst_n;
            btn_raw = vecs[i].raw;
            @(posedge clk);
            @(negedge clk);
            check("vec", i, {21'd0, btn_level, btn_press, btn_release, any_press},
                  {21'd0, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].any});
        end

        // ch1 alone after reset release: press 6 edges later, ch0 silent
        rst_n   = 1'b1;
        btn_raw = 2'b10;
        found = 0;
        n = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            @(negedge clk);
            n = k;
            if (btn_press != 2'b00) found = 1;
        end
        check("press_found", 0, {31'd0, found}, 32'd1);
        check("press_latency", 0, n, 6);
        check("press_bits", 0, {30'd0, btn_press}, 32'd2);

        // hold through n=36: repeats at 16,21,26,31,36 only when enabled
        bad = 0;
        for (int k = 7; k <= 36; k++) begin
            logic exp_p;
            @(posedge clk);
            @(negedge clk);
            exp_p = REP_ON && (k >= 6 + RD) && (((k - 6 - RD) % RP) == 0);
            if (btn_press !== {exp_p, 1'b0} || any_press !== exp_p || btn_level !== 2'b10) begin
                bad++;
                $display("FAIL hold[%0d]: press=%b any=%b level=%b, expected press=%b any=%b level=10",
                         k, btn_press, any_press, btn_level, {exp_p, 1'b0}, exp_p);
            end
        end
        check("hold_errors", 0, bad, 0);

        // release ch1: release pulse 6 edges later, no press during the fall
        btn_raw = 2'b00;
        found = 0;
        n = 0;
        bad = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            @(negedge clk);
            n = k;
            if (btn_press != 2'b00 || any_press) bad++;
            if (btn_release != 2'b00) found = 1;
        end
        check("release_found", 0, {31'd0, found}, 32'd1);
        check("release_latency", 0, n, 6);
        check("release_bits", 0, {30'd0, btn_release}, 32'd2);
        check("release_level", 0, {30'd0, btn_level}, 32'd0);
        check("release_no_press", 0, bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
